tetris_soc_gravity_tick: RTL
============================

Name: tetris_soc_gravity_tick

Overview:
- Sits directly downstream of the system interval timer.
- Consumes the timer's irq line and acknowledges each timeout itself by writing the timer's status register through a small Avalon-MM master port.
- Divides the acknowledged timer ticks by a software-programmed gravity period and emits single-cycle drop_tick pulses to the game logic.
- Keeps a saturating count of pending drops for the Nios CPU, behind a 16-bit Avalon-MM slave, with its own interrupt.

Parameters:
- DIV_W, 12, width of the tick divisor registers and the tick counter.
- PEND_W, 4, width of the pending-drop counter.
- NORMAL_DIV_RST, 1000, reset value of NORMAL_DIV (1 s at the timer's 1 ms reset period).
- SOFT_DIV_RST, 50, reset value of SOFT_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  4  slave word address.
- chipselect  in  1  slave select.
- write_n  in  1  slave write, active low.
- writedata  in  16  slave write data.
- readdata  out  16  slave read data, registered.
- irq  out  1  CPU interrupt.
- timer_irq  in  1  interval timer irq (level, held until the timer status is written).
- avm_address  out  4  master address to the timer.
- avm_write  out  1  master write request.
- avm_writedata  out  16  master write data.
- avm_waitrequest  in  1  master stall.
- drop_tick  out  1  one-cycle gravity pulse to the game logic.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; tick_cnt=0; pending=0; ovf=0; CONTROL=0; NORMAL_DIV=NORMAL_DIV_RST; SOFT_DIV=SOFT_DIV_RST.
- Slave registers (reads return zero in unused bits; unmapped addresses read 0, writes to them are ignored):
  - Address 0, STATUS: [PEND_W-1:0] pending, [15] ovf. A write decrements pending by writedata[3:0], floored at 0. writedata[15]=1 clears ovf.
  - Address 1, CONTROL: [0] en, [1] irq_en, [2] soft.
  - Address 2, NORMAL_DIV [DIV_W-1:0].
  - Address 3, SOFT_DIV [DIV_W-1:0].
  - Address 4, TICK_COUNT: read-only tick_cnt.
- readdata is registered every cycle from the read mux; 1-cycle latency, no wait states.
- Acknowledge FSM:
  - IDLE: when timer_irq=1, assert tick for one cycle, then go to ACK.
  - ACK: drive avm_write=1, avm_address=0, avm_writedata=0. Hold all three stable while avm_waitrequest=1. On a cycle with avm_waitrequest=0, go to WAIT_LOW.
  - WAIT_LOW: stay until timer_irq=0, then go to IDLE. This prevents double-counting one timeout.
  - avm_writedata is 0 in every state.
- Tick processing:
  - The FSM always acknowledges, whatever en is.
  - A tick counts only when en=1.
  - Effective divisor = (soft ? SOFT_DIV : NORMAL_DIV), with 0 treated as 1.
  - On a counted tick: if tick_cnt+1 >= divisor, then tick_cnt<=0, drop_tick=1 in the next cycle, and a pending increment is requested. Otherwise tick_cnt<=tick_cnt+1.
  - en=0 forces tick_cnt<=0.
  - Changing a divisor or soft does not clear tick_cnt. If the new divisor is <= tick_cnt, the next counted tick fires.
- pending:
  - Next value = sat(pending + inc - dec), range 0..2^PEND_W-1.
  - An increment at full saturates pending and sets ovf.
  - An increment and a STATUS write in the same cycle are both applied in that cycle.
- irq = irq_en && (pending != 0); combinational from registers.
- Reset asserted mid-handshake: the FSM returns to IDLE and avm_write drops immediately. The timer irq is re-acknowledged after reset is released.

Decomposition:
- Shared package tetris_soc_pkg holds:
  - register address constants (GRAV_STATUS=0 … GRAV_TICKCNT=4);
  - the CONTROL bit indices;
  - TIMER_STATUS_ADDR=0;
  - the FSM state enum {IDLE, ACK, WAIT_LOW}.
- One sub-module, tetris_soc_tick_ack_fsm, owns the acknowledge FSM and the master port and outputs the one-cycle tick. The divider, pending counter and register file stay in the top.

Test Plan:
- Reset, then read addresses 0..4 -> 0x0000, 0x0000, 0x03E8, 0x0032, 0x0000; irq=0; drop_tick=0.
- en=1, NORMAL_DIV=3; model the timer asserting timer_irq until the ack write with waitrequest low -> exactly one avm_write per timeout; drop_tick on every third tick; pending increments by 1 per drop.
- Hold avm_waitrequest=1 for 5 cycles during ACK -> avm_write, avm_address and avm_writedata stable for 6 cycles; no second tick while timer_irq stays high in WAIT_LOW.
- NORMAL_DIV=1; generate 17 drops with no STATUS writes -> pending=15, ovf=1, STATUS reads 0x800F; write 0x8005 -> STATUS 0x000A.
- STATUS write decrementing by 1 in the same cycle as a drop increment at pending=4 -> pending=4; irq_en=1 -> irq=1; write 0x0004 -> irq=0 next cycle.
- NORMAL_DIV=10 with tick_cnt=6; switch soft=1 with SOFT_DIV=2 -> drop_tick on the next counted tick; tick_cnt=0 afterwards.

Source files
------------

// File: rtl/tetris_soc_pkg.sv
//------------------------------------------------------------------------------
// tetris_soc_pkg : shared constants and types for the gravity tick block
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tetris_soc_pkg;

   // Slave register word addresses
   localparam logic [3:0] GRAV_STATUS   = 4'd0;
   localparam logic [3:0] GRAV_CONTROL  = 4'd1;
   localparam logic [3:0] GRAV_NORMDIV  = 4'd2;
   localparam logic [3:0] GRAV_SOFTDIV  = 4'd3;
   localparam logic [3:0] GRAV_TICKCNT  = 4'd4;

   // CONTROL register bit positions
   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_SOFT   = 2;

   // Interval timer status register address
   localparam logic [3:0] TIMER_STATUS_ADDR = 4'd0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } ack_state_e;

endpackage

`default_nettype wire

// File: rtl/tetris_soc_tick_ack_fsm.sv
//------------------------------------------------------------------------------
// tetris_soc_tick_ack_fsm : acknowledges interval-timer timeouts over Avalon-MM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tetris_soc_tick_ack_fsm
   import tetris_soc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        timer_irq_i,
   input  logic        avm_waitrequest_i,
   output logic [3:0]  avm_address_o,
   output logic        avm_write_o,
   output logic [15:0] avm_writedata_o,
   output logic        tick_o
);

   ack_state_e state_q;
   ack_state_e state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_o      = 1'b0;
      avm_write_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (timer_irq_i) begin
               tick_o  = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            avm_write_o = 1'b1;
            if (!avm_waitrequest_i) begin
               state_d = WAIT_LOW;
            end
         end
         // The timer irq may lag the status write; wait for it to fall so one
         // timeout is never counted twice.
         WAIT_LOW: begin
            if (!timer_irq_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign avm_address_o   = TIMER_STATUS_ADDR;
   assign avm_writedata_o = 16'h0000;

endmodule

`default_nettype wire

// File: rtl/tetris_soc_gravity_tick.sv
//------------------------------------------------------------------------------
// tetris_soc_gravity_tick : divides timer ticks into gravity drops, CPU regfile
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tetris_soc_gravity_tick
   import tetris_soc_pkg::*;
#(
   parameter int DIV_W          = 12,
   parameter int PEND_W         = 4,
   parameter int NORMAL_DIV_RST = 1000,
   parameter int SOFT_DIV_RST   = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   input  logic        timer_irq,
   output logic [3:0]  avm_address,
   output logic        avm_write,
   output logic [15:0] avm_writedata,
   input  logic        avm_waitrequest,
   output logic        drop_tick
);

   localparam int SUM_W = ((PEND_W > 4) ? PEND_W : 4) + 1;
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   logic [2:0]        ctrl_q, ctrl_d;
   logic [DIV_W-1:0]  ndiv_q, ndiv_d;
   logic [DIV_W-1:0]  sdiv_q, sdiv_d;
   logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              ovf_q, ovf_d;
   logic              drop_q, drop_d;
   logic [15:0]       readdata_q, readdata_d;

   logic              w_tick;
   logic              w_wr;
   logic              w_en;
   logic [DIV_W-1:0]  w_div_sel;
   logic [DIV_W-1:0]  w_div_eff;
   logic [DIV_W:0]    w_cnt_inc;
   logic              w_fire;
   logic [SUM_W-1:0]  w_sum;
   logic [SUM_W-1:0]  w_dec;
   logic [SUM_W-1:0]  w_diff;
   logic              w_unused_wd;

   tetris_soc_tick_ack_fsm u_ack_fsm (
      .clk               (clk),
      .reset             (reset),
      .timer_irq_i       (timer_irq),
      .avm_waitrequest_i (avm_waitrequest),
      .avm_address_o     (avm_address),
      .avm_write_o       (avm_write),
      .avm_writedata_o   (avm_writedata),
      .tick_o            (w_tick)
   );

   assign w_wr        = chipselect && !write_n;
   assign w_en        = ctrl_q[CTRL_EN];
   assign w_div_sel   = ctrl_q[CTRL_SOFT] ? sdiv_q : ndiv_q;
   assign w_div_eff   = (w_div_sel == '0) ? DIV_W'(1) : w_div_sel;
   assign w_cnt_inc   = (DIV_W+1)'(tick_cnt_q) + (DIV_W+1)'(1);
   assign w_fire      = (w_cnt_inc >= (DIV_W+1)'(w_div_eff));
   assign w_unused_wd = ^writedata;

   // A divisor shrinking below tick_cnt makes the next counted tick fire.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      drop_d     = 1'b0;
      if (!w_en) begin
         tick_cnt_d = '0;
      end else if (w_tick) begin
         if (w_fire) begin
            tick_cnt_d = '0;
            drop_d     = 1'b1;
         end else begin
            tick_cnt_d = w_cnt_inc[DIV_W-1:0];
         end
      end
   end

   // Increment and STATUS-write decrement land together in one update.
   always_comb begin
      w_dec = '0;
      if (w_wr && (address == GRAV_STATUS)) begin
         w_dec = SUM_W'(writedata[3:0]);
      end
      w_sum  = SUM_W'(pending_q) + SUM_W'(drop_d);
      w_diff = w_sum - w_dec;
      ovf_d  = ovf_q;
      if (w_wr && (address == GRAV_STATUS) && writedata[15]) begin
         ovf_d = 1'b0;
      end
      if (drop_d && (pending_q == PEND_MAX)) begin
         ovf_d = 1'b1;
      end
      if (w_sum < w_dec) begin
         pending_d = '0;
      end else if (w_diff > SUM_W'(PEND_MAX)) begin
         pending_d = PEND_MAX;
      end else begin
         pending_d = w_diff[PEND_W-1:0];
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      ndiv_d = ndiv_q;
      sdiv_d = sdiv_q;
      if (w_wr) begin
         case (address)
            GRAV_CONTROL: ctrl_d = writedata[2:0];
            GRAV_NORMDIV: ndiv_d = writedata[DIV_W-1:0];
            GRAV_SOFTDIV: sdiv_d = writedata[DIV_W-1:0];
            default:      ;
         endcase
      end
   end

   always_comb begin
      readdata_d = 16'h0000;
      case (address)
         GRAV_STATUS: begin
            readdata_d     = 16'(pending_q);
            readdata_d[15] = ovf_q;
         end
         GRAV_CONTROL: readdata_d = 16'(ctrl_q);
         GRAV_NORMDIV: readdata_d = 16'(ndiv_q);
         GRAV_SOFTDIV: readdata_d = 16'(sdiv_q);
         GRAV_TICKCNT: readdata_d = 16'(tick_cnt_q);
         default:      readdata_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q     <= '0;
         ndiv_q     <= DIV_W'(NORMAL_DIV_RST);
         sdiv_q     <= DIV_W'(SOFT_DIV_RST);
         tick_cnt_q <= '0;
         pending_q  <= '0;
         ovf_q      <= 1'b0;
         drop_q     <= 1'b0;
         readdata_q <= 16'h0000;
      end else begin
         ctrl_q     <= ctrl_d;
         ndiv_q     <= ndiv_d;
         sdiv_q     <= sdiv_d;
         tick_cnt_q <= tick_cnt_d;
         pending_q  <= pending_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata  = readdata_q;
   assign drop_tick = drop_q;
   assign irq       = ctrl_q[CTRL_IRQ_EN] && (pending_q != '0);

endmodule

`default_nettype wire
